ibex_rf_wb_arbiter: RTL and testbench

IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

---
 rtl/ibex_rf_wb_arbiter_pkg.sv | 15 +
 rtl/ibex_rf_pending_fifo.sv | 71 +++++++
 rtl/ibex_rf_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wb_arbiter_pkg.sv
// Shared register-address definitions for the register-file write-back arbiter
// and its pending-load FIFO.
package ibex_rf_wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  localparam reg_addr_t RegX0 = '0;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == RegX0;
  endfunction

endpackage

// File: rtl/ibex_rf_pending_fifo.sv
// In-order FIFO of destination registers for outstanding loads; every entry and its
// valid bit are exposed so the decode stage can detect load-use hazards.
module ibex_rf_pending_fifo
  import ibex_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  reg_addr_t               push_addr_i,
  input  logic                    pop_i,
  output reg_addr_t               head_addr_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic      [Depth-1:0]   entry_valid_o,
  output reg_addr_t [Depth-1:0]   entry_addr_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  reg_addr_t [Depth-1:0] mem_q;
  logic      [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic      [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic      [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CntOne;
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Address storage is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_addr_i;
    end
  end

  for (genvar i = 0; i < Depth; i++) begin : g_valid
    logic [PtrW-1:0] offset;
    assign offset           = PtrW'(i) - rd_ptr_q;
    assign entry_valid_o[i] = {1'b0, offset} < count_q;
  end

  assign head_addr_o  = mem_q[rd_ptr_q];
  assign entry_addr_o = mem_q;
  assign full_o       = count_q == CntW'(Depth);
  assign empty_o      = count_q == '0;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU results and in-order
// load responses, with a one-entry holding register for loads that lose arbitration.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LoadDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [RegAddrW-1:0]  ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [RegAddrW-1:0]  lsu_req_waddr_i,
  output logic                 lsu_req_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [RegAddrW-1:0]  raddr_a_i,
  input  logic [RegAddrW-1:0]  raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [RegAddrW-1:0]  rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  logic                       fifo_full, fifo_empty;
  logic                       fifo_push, fifo_pop;
  reg_addr_t                  fifo_head;
  logic      [LoadDepth-1:0]  fifo_valid;
  reg_addr_t [LoadDepth-1:0]  fifo_addr;

  logic                 hold_valid_q, hold_valid_d;
  reg_addr_t            hold_addr_q, hold_addr_d;
  logic [DataWidth-1:0] hold_data_q, hold_data_d;
  logic                 err_q, err_d;

  logic                 resp_empty_err, req_full_err;
  logic                 load_wr;
  logic                 sel_valid;
  reg_addr_t            sel_addr;
  logic [DataWidth-1:0] sel_data;

  ibex_rf_pending_fifo #(
    .Depth (LoadDepth)
  ) u_pending_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (fifo_push),
    .push_addr_i   (lsu_req_waddr_i),
    .pop_i         (fifo_pop),
    .head_addr_o   (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (fifo_valid),
    .entry_addr_o  (fifo_addr)
  );

  // A response on a full FIFO frees a slot in the same cycle.
  assign lsu_req_ready_o = !fifo_full || lsu_rvalid_i;
  assign ex_ready_o      = !hold_valid_q;

  assign resp_empty_err = lsu_rvalid_i && fifo_empty;
  assign req_full_err   = lsu_req_i && !lsu_req_ready_o;
  assign fifo_pop       = lsu_rvalid_i && !fifo_empty;
  assign fifo_push      = lsu_req_i && lsu_req_ready_o && !resp_empty_err;

  // Errored and x0 responses retire from the FIFO but never occupy the write port.
  assign load_wr = fifo_pop && !lsu_err_i && !is_x0(fifo_head);

  always_comb begin
    sel_valid    = 1'b0;
    sel_addr     = RegX0;
    sel_data     = '0;
    hold_valid_d = 1'b0;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (load_wr) begin
      hold_addr_d = fifo_head;
      hold_data_d = lsu_rdata_i;
    end
    if (hold_valid_q) begin
      sel_valid    = 1'b1;
      sel_addr     = hold_addr_q;
      sel_data     = hold_data_q;
      hold_valid_d = load_wr;
    end else if (ex_we_i) begin
      sel_valid    = 1'b1;
      sel_addr     = ex_waddr_i;
      sel_data     = ex_wdata_i;
      hold_valid_d = load_wr;
    end else if (load_wr) begin
      sel_valid    = 1'b1;
      sel_addr     = fifo_head;
      sel_data     = lsu_rdata_i;
    end
  end

  assign rf_we_o    = sel_valid && !is_x0(sel_addr);
  assign rf_waddr_o = sel_addr;
  assign rf_wdata_o = sel_data;

  assign err_d = err_q || resp_empty_err || req_full_err;
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int i = 0; i < int'(LoadDepth); i++) begin
      if (fifo_valid[i] && fifo_addr[i] == raddr_a_i) hazard_a_o = 1'b1;
      if (fifo_valid[i] && fifo_addr[i] == raddr_b_i) hazard_b_o = 1'b1;
    end
    if (hold_valid_q && hold_addr_q == raddr_a_i) hazard_a_o = 1'b1;
    if (hold_valid_q && hold_addr_q == raddr_b_i) hazard_b_o = 1'b1;
    if (is_x0(raddr_a_i)) hazard_a_o = 1'b0;
    if (is_x0(raddr_b_i)) hazard_b_o = 1'b0;
  end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_ibex_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int LD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_we, ex_ready;
  logic [4:0]    ex_waddr;
  logic [DW-1:0] ex_wdata;
  logic          lsu_req, lsu_req_ready;
  logic [4:0]    lsu_req_waddr;
  logic          lsu_rvalid, lsu_err;
  logic [DW-1:0] lsu_rdata;
  logic [4:0]    raddr_a, raddr_b;
  logic          hazard_a, hazard_b;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          err;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.DataWidth(DW), .LoadDepth(LD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_req_i(lsu_req), .lsu_req_waddr_i(lsu_req_waddr), .lsu_req_ready_o(lsu_req_ready),
    .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(hazard_a), .hazard_b_o(hazard_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .err_o(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of pending destinations, one held result, sticky error.
  logic [4:0]    pend[$];
  bit            hv;
  logic [4:0]    ha;
  logic [DW-1:0] hd;
  bit            merr;
  bit            n_hv, n_push, n_pop, n_merr;
  logic [4:0]    n_ha, n_pa;
  logic [DW-1:0] n_hd;

  function automatic bit pending_on(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (hv && ha == a) return 1'b1;
    foreach (pend[i]) if (pend[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    pend.delete();
    hv   = 1'b0;
    merr = 1'b0;
  endtask

  task automatic idle();
    ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    lsu_req = 0; lsu_req_waddr = 0;
    lsu_rvalid = 0; lsu_rdata = 0; lsu_err = 0;
    raddr_a = 0; raddr_b = 0;
  endtask

  task automatic at_neg();
    bit ready, popped, ld, ew;
    logic [4:0] head, ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    ready  = (pend.size() < LD) || lsu_rvalid;
    popped = lsu_rvalid && pend.size() > 0;
    head   = popped ? pend[0] : 5'd0;
    ld     = popped && !lsu_err && head != 5'd0;
    ew = 0; ea = 0; ed = 0;
    if (hv)         begin ew = 1; ea = ha;       ed = hd;        end
    else if (ex_we) begin ew = 1; ea = ex_waddr; ed = ex_wdata;  end
    else if (ld)    begin ew = 1; ea = head;     ed = lsu_rdata; end
    chk("ex_ready", ex_ready, !hv);
    chk("lsu_req_ready", lsu_req_ready, ready);
    chk("rf_we", rf_we, ew && ea != 5'd0);
    if (ew && ea != 5'd0) begin
      chk("rf_waddr", rf_waddr, ea);
      chk("rf_wdata", rf_wdata, ed);
    end
    chk("hazard_a", hazard_a, pending_on(raddr_a));
    chk("hazard_b", hazard_b, pending_on(raddr_b));
    chk("err", err, merr);
    n_hv   = (hv || ex_we) && ld;
    n_ha   = ld ? head : ha;
    n_hd   = ld ? lsu_rdata : hd;
    n_pop  = popped;
    n_push = lsu_req && ready && !(lsu_rvalid && pend.size() == 0);
    n_pa   = lsu_req_waddr;
    n_merr = merr || (lsu_rvalid && pend.size() == 0) || (lsu_req && !ready);
  endtask

  task automatic to_pos();
    if (n_pop) void'(pend.pop_front());
    if (n_push) pend.push_back(n_pa);
    hv = n_hv; ha = n_ha; hd = n_hd; merr = n_merr;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    to_pos();
  endtask

  task automatic issue(input logic [4:0] a);
    idle(); lsu_req = 1; lsu_req_waddr = a;
    step();
  endtask

  task automatic apply_reset();
    idle();
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_lsu_ready", lsu_req_ready, 1);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_ex_ready", ex_ready, 1);
    chk("reset_lsu_ready", lsu_req_ready, 1);
    chk("reset_err", err, 0);
    chk("reset_hazard_a", hazard_a, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Load x5 written with zero latency, hazard visible until the write cycle.
    idle(); lsu_req = 1; lsu_req_waddr = 5; raddr_a = 5;
    step();
    idle(); raddr_a = 5;
    at_neg(); chk("ld5_hazard_wait", hazard_a, 1); to_pos();
    idle(); raddr_a = 5; lsu_rvalid = 1; lsu_rdata = 32'hDEADBEEF;
    at_neg();
    chk("ld5_we", rf_we, 1);
    chk("ld5_waddr", rf_waddr, 5);
    chk("ld5_wdata", rf_wdata, 32'hDEADBEEF);
    chk("ld5_hazard_wr", hazard_a, 1);
    to_pos();
    idle(); raddr_a = 5;
    at_neg(); chk("ld5_hazard_clr", hazard_a, 0); to_pos();

    // Load x7 collides with ALU write x3.
    issue(7);
    idle(); ex_we = 1; ex_waddr = 3; ex_wdata = 32'h11; lsu_rvalid = 1; lsu_rdata = 32'h77;
    at_neg(); chk("col_alu_addr", rf_waddr, 3); chk("col_alu_data", rf_wdata, 32'h11); to_pos();
    idle();
    at_neg(); chk("col_ex_ready", ex_ready, 0); chk("col_ld_addr", rf_waddr, 7); to_pos();
    step();

    // x0 load and errored load to x9.
    issue(0);
    issue(9);
    idle(); lsu_rvalid = 1; lsu_rdata = 32'h55;
    at_neg(); chk("x0_we", rf_we, 0); to_pos();
    idle(); lsu_rvalid = 1; lsu_err = 1; raddr_b = 9;
    at_neg(); chk("lerr_we", rf_we, 0); to_pos();
    idle(); raddr_b = 9;
    at_neg(); chk("lerr_hazard", hazard_b, 0); to_pos();

    // Holding valid with back-to-back responses x4, x6.
    issue(2);
    issue(4);
    idle(); ex_we = 1; ex_waddr = 1; ex_wdata = 32'hA1;
    lsu_rvalid = 1; lsu_rdata = 32'hB2; lsu_req = 1; lsu_req_waddr = 6;
    step();
    idle(); lsu_rvalid = 1; lsu_rdata = 32'hB4;
    at_neg(); chk("b2b_held", rf_waddr, 2); to_pos();
    idle(); lsu_rvalid = 1; lsu_rdata = 32'hB6;
    at_neg(); chk("b2b_x4", rf_waddr, 4); to_pos();
    idle();
    at_neg(); chk("b2b_x6", rf_waddr, 6); chk("b2b_x6_data", rf_wdata, 32'hB6); to_pos();
    step();

    // Random legal traffic.
    for (int c = 0; c < 600; c++) begin
      idle();
      ex_we         = 1'($urandom_range(0, 1));
      ex_waddr      = 5'($urandom_range(0, 7));
      ex_wdata      = $urandom;
      lsu_rvalid    = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      lsu_rdata     = $urandom;
      lsu_err       = ($urandom_range(0, 7) == 0);
      lsu_req       = ((pend.size() < LD) || lsu_rvalid) && ($urandom_range(0, 1) == 1);
      lsu_req_waddr = 5'($urandom_range(0, 7));
      raddr_a       = 5'($urandom_range(0, 7));
      raddr_b       = 5'($urandom_range(0, 7));
      step();
    end

    apply_reset();

    // Third load while full raises a sticky error.
    issue(10);
    issue(11);
    idle(); lsu_req = 1; lsu_req_waddr = 12;
    at_neg(); chk("full_ready", lsu_req_ready, 0); to_pos();
    idle();
    at_neg(); chk("full_err", err, 1); to_pos();
    repeat (3) step();
    idle(); lsu_rvalid = 1; lsu_rdata = 32'hC0;
    step(); step();
    idle();
    at_neg(); chk("err_sticky", err, 1); to_pos();

    // Reset with two pending loads and holding valid.
    issue(2);
    issue(4);
    idle(); ex_we = 1; ex_waddr = 1; ex_wdata = 32'hA1;
    lsu_rvalid = 1; lsu_rdata = 32'hD2; lsu_req = 1; lsu_req_waddr = 6;
    step();
    idle(); raddr_a = 4; raddr_b = 6;
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_ex_ready", ex_ready, 1);
    chk("mid_rst_lsu_ready", lsu_req_ready, 1);
    chk("mid_rst_hazard_a", hazard_a, 0);
    chk("mid_rst_hazard_b", hazard_b, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      idle(); raddr_a = 4; raddr_b = 6;
      at_neg(); chk("post_rst_we", rf_we, 0); to_pos();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
